// File: rtl/fsrc_seq_arbiter.sv
// Round-robin arbiter feeding ctrl-change requests to the TX FSRC sequencer.
// One request is accepted per sequence: IDLE -> START -> WAIT -> DONE.
module fsrc_seq_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned CTRL_WIDTH    = 40,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][CTRL_WIDTH-1:0]  req_ctrl,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                seq_start,
    output logic [CTRL_WIDTH-1:0]               seq_next_ctrl,
    input  logic                                seq_done,
    input  logic [TIMEOUT_WIDTH-1:0]            timeout_cycles,
    input  logic                                err_clear,
    output logic                                busy,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id,
    output logic                                done_pulse,
    output logic                                timeout_err
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            last_grant_q, last_grant_d;
    logic [GW-1:0]            grant_id_q, grant_id_d;
    logic [CTRL_WIDTH-1:0]    seq_next_ctrl_q, seq_next_ctrl_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     seq_start_q, seq_start_d;
    logic                     done_pulse_q, done_pulse_d;
    logic                     busy_q, busy_d;
    logic                     timeout_err_q, timeout_err_d;

    logic                     win_found;
    logic [GW-1:0]            win_idx;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[GW'((32'(last_grant_q) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = GW'((32'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    // Combinational one-hot accept, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!reset && (state_q == ST_IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_id_d      = grant_id_q;
        seq_next_ctrl_d = seq_next_ctrl_q;
        cnt_d           = cnt_q;
        seq_start_d     = 1'b0;
        done_pulse_d    = 1'b0;
        timeout_err_d   = timeout_err_q;

        // Clear first so a same-cycle timeout below takes priority.
        if (err_clear) begin
            timeout_err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    seq_next_ctrl_d = req_ctrl[win_idx];
                    grant_id_d      = win_idx;
                    state_d         = ST_START;
                end
            end
            ST_START: begin
                seq_start_d = 1'b1;
                cnt_d       = timeout_cycles;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TIMEOUT_WIDTH'(1);
                end
                // A zero load never reaches 1, which disables the timeout.
                if (seq_done) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_WIDTH'(1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                done_pulse_d = 1'b1;
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= GW'(NUM_REQ - 1);
            grant_id_q      <= '0;
            seq_next_ctrl_q <= '0;
            cnt_q           <= '0;
            seq_start_q     <= 1'b0;
            done_pulse_q    <= 1'b0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_id_q      <= grant_id_d;
            seq_next_ctrl_q <= seq_next_ctrl_d;
            cnt_q           <= cnt_d;
            seq_start_q     <= seq_start_d;
            done_pulse_q    <= done_pulse_d;
            busy_q          <= busy_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign seq_start     = seq_start_q;
    assign seq_next_ctrl = seq_next_ctrl_q;
    assign grant_id      = grant_id_q;
    assign done_pulse    = done_pulse_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_fsrc_seq_arbiter.sv
// Scoreboard bench for fsrc_seq_arbiter: driver pushes expectations, monitor checks.
`timescale 1ns/1ps
module tb_fsrc_seq_arbiter;

    localparam int N  = 3;
    localparam int CW = 40;
    localparam int TW = 16;
    localparam int GW = $clog2(N);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0][CW-1:0]   req_ctrl;
    logic [N-1:0]           req_ready;
    logic                   seq_start;
    logic [CW-1:0]          seq_next_ctrl;
    logic                   seq_done;
    logic [TW-1:0]          timeout_cycles;
    logic                   err_clear;
    logic                   busy;
    logic [GW-1:0]          grant_id;
    logic                   done_pulse;
    logic                   timeout_err;

    fsrc_seq_arbiter #(
        .NUM_REQ       (N),
        .CTRL_WIDTH    (CW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ctrl       (req_ctrl),
        .req_ready      (req_ready),
        .seq_start      (seq_start),
        .seq_next_ctrl  (seq_next_ctrl),
        .seq_done       (seq_done),
        .timeout_cycles (timeout_cycles),
        .err_clear      (err_clear),
        .busy           (busy),
        .grant_id       (grant_id),
        .done_pulse     (done_pulse),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int            win;
        logic [CW-1:0] ctrl;
    } hs_t;

    typedef struct {
        bit err;
        int cyc;
    } done_t;

    hs_t   hs_q[$];
    done_t done_q[$];

    int model_last;
    bit model_err;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: output pulse seen at cycle %0d, none expected", nm, cyc);
    endtask

    // Round-robin rule: first set bit scanning upward from last+1, wrapping.
    function automatic int rr_pick(input int last, input logic [N-1:0] pat);
        for (int k = 1; k <= N; k++) begin
            if (pat[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [CW-1:0] rand_ctrl();
        return CW'({$urandom, $urandom});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seq_start"},     seq_start,     0);
        check({tag, "_done_pulse"},    done_pulse,    0);
        check({tag, "_timeout_err"},   timeout_err,   0);
        check({tag, "_busy"},          busy,          0);
        check({tag, "_req_ready"},     req_ready,     0);
        check({tag, "_seq_next_ctrl"}, seq_next_ctrl, 0);
        check({tag, "_grant_id"},      grant_id,      0);
    endtask

    // Monitor: compares DUT events against the expectation queues.
    initial begin : monitor
        bit    cur_v;
        hs_t   cur;
        done_t dexp;
        int    hs_cyc;
        logic [N-1:0] exp_rdy;
        cur_v  = 1'b0;
        hs_cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                cur_v = 1'b0;
            end else begin
                if (done_pulse) begin
                    if (!cur_v || done_q.size() == 0) begin
                        unexpected("done_pulse");
                    end else begin
                        dexp = done_q.pop_front();
                        check("done_cycle", 64'(cyc), 64'(dexp.cyc));
                        check("done_timeout_err", timeout_err, dexp.err);
                        check("done_busy", busy, 0);
                        check("done_ctrl_held", seq_next_ctrl, cur.ctrl);
                    end
                    cur_v = 1'b0;
                end
                if (seq_start) begin
                    if (!cur_v) begin
                        unexpected("seq_start");
                    end else begin
                        check("seq_start_latency", 64'(cyc - hs_cyc), 2);
                        check("seq_next_ctrl", seq_next_ctrl, cur.ctrl);
                        check("grant_id", grant_id, 64'(cur.win));
                        check("busy_in_seq", busy, 1);
                    end
                end
                if (req_ready != '0) begin
                    if (hs_q.size() == 0) begin
                        unexpected("req_ready");
                    end else begin
                        cur     = hs_q.pop_front();
                        cur_v   = 1'b1;
                        hs_cyc  = cyc;
                        exp_rdy = '0;
                        exp_rdy[cur.win] = 1'b1;
                        check("req_ready_onehot", req_ready, exp_rdy);
                        check("busy_at_handshake", busy, 0);
                    end
                end
            end
        end
    end

    // One request/sequence transaction; returns at the negedge of the DONE cycle.
    task automatic run_txn(input logic [N-1:0] pat, input int gap, input bit hold,
                           input int d, input int t, input bit clr_exp, input bit clr_start,
                           input bit chg_ctrl, input bit use_fixed, input logic [CW-1:0] fixed);
        int  w;
        int  n;
        int  s;
        int  last;
        bit  to;
        bit  exp_err;
        // Idle gap: requests withdrawn, stray seq_done pulses, error clear.
        for (int i = 0; i < gap; i++) begin
            req_valid = '0;
            seq_done  = 1'($urandom_range(0, 1));
            err_clear = (i == 1);
            if (i == 1) model_err = 1'b0;
            if (i == 2) check("err_clear", timeout_err, 0);
            @(negedge clk);
        end
        err_clear      = 1'b0;
        req_valid      = pat;
        seq_done       = 1'($urandom_range(0, 1));
        timeout_cycles = TW'(t);
        for (int k = 0; k < N; k++) req_ctrl[k] = use_fixed ? fixed : rand_ctrl();
        w          = rr_pick(model_last, pat);
        model_last = w;
        hs_q.push_back('{win: w, ctrl: req_ctrl[w]});

        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            seq_done = 1'b0;
            #1;
            n++;
        end
        if (n >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_wait: req_ready stayed 0 for 20 cycles, pattern %b", pat);
            void'(hs_q.pop_back());
            req_valid = '0;
            return;
        end
        seq_done = 1'b0;

        @(negedge clk);
        seq_done  = 1'($urandom_range(0, 1));
        err_clear = clr_start;
        if (clr_start) model_err = 1'b0;
        if (!hold) req_valid = '0;

        @(negedge clk);
        seq_done  = 1'b0;
        err_clear = 1'b0;
        s         = cyc;
        to        = (t != 0) && (d >= t);
        exp_err   = to || model_err;
        model_err = exp_err;
        last      = to ? (s + t) : (s + d + 1);
        done_q.push_back('{err: exp_err, cyc: last + 1});

        for (int c = s; c < last; c++) begin
            seq_done  = !to && (c == s + d);
            err_clear = clr_exp && to && (c == s + t - 1);
            if (chg_ctrl && c == s + 1) begin
                for (int k = 0; k < N; k++) req_ctrl[k] = rand_ctrl();
            end
            @(negedge clk);
        end
        seq_done  = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin : driver
        logic [N-1:0] pat;
        int           t;
        int           n;
        reset          = 1'b1;
        req_valid      = '1;
        for (int k = 0; k < N; k++) req_ctrl[k] = rand_ctrl();
        seq_done       = 1'b0;
        timeout_cycles = '0;
        err_clear      = 1'b0;
        model_last     = N - 1;
        model_err      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);

        // All requesting after reset: requester 0 first.
        run_txn(3'b111, 0, 0, 3, 0, 0, 0, 0, 0, '0);
        // Single request with a known ctrl word, seq_done 5 cycles after start.
        run_txn(3'b010, 2, 0, 5, 0, 0, 0, 0, 1, 40'h12_3456_789A);
        // Two requesters held continuously: strict alternation.
        for (int i = 0; i < 4; i++) run_txn(3'b011, 0, 1, $urandom_range(0, 4), 0, 0, 0, 0, 0, '0);
        // Timeout of 10 with no seq_done.
        run_txn(3'b001, 1, 0, 50, 10, 0, 0, 0, 0, '0);
        // seq_done on the expiry cycle wins; ctrl changes during WAIT.
        run_txn(3'b100, 3, 0, 9, 10, 0, 0, 1, 0, '0);
        // Timeout disabled, very late seq_done.
        run_txn(3'b010, 0, 0, 1000, 0, 0, 0, 0, 0, '0);
        // Clear coinciding with expiry: set wins.
        run_txn(3'b001, 0, 0, 20, 4, 1, 0, 0, 0, '0);
        // Clear during START removes the sticky flag.
        run_txn(3'b110, 0, 0, 2, 0, 0, 1, 0, 0, '0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            pat = N'($urandom_range(1, (1 << N) - 1));
            t   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            run_txn(pat, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 15), t,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 0, '0);
        end

        // Reset in WAIT aborts the sequence.
        req_valid      = 3'b001;
        timeout_cycles = '0;
        model_last     = rr_pick(model_last, 3'b001);
        hs_q.push_back('{win: model_last, ctrl: req_ctrl[model_last]});
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            seq_done = 1'b0;
            #1;
            n++;
        end
        if (n >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL reset_txn_handshake: req_ready stayed 0 for 20 cycles");
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        hs_q.delete();
        done_q.delete();
        model_last = N - 1;
        model_err  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_txn(3'b010, 0, 0, 4, 0, 0, 0, 0, 0, '0);

        req_valid = '0;
        repeat (6) @(negedge clk);
        check("queues_drained", 64'(hs_q.size() + done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fsrc_seq_arbiter.md
FSRC_SEQ_ARBITER -- requirements
Module: fsrc_seq_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of requesters, range 2..8.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 40: width of the FSRC ctrl word.
REQ-003 The block SHALL have parameter TIMEOUT_WIDTH, default 16: width of the completion timeout counter.
REQ-004 The block SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ: per-requester ctrl-change request.
REQ-007 The block SHALL have port req_ctrl, input, NUM_REQ x CTRL_WIDTH: per-requester ctrl value, valid while req_valid is high.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ: one-hot accept.
REQ-009 The block SHALL have port seq_start, output, 1: single-cycle start pulse to the TX FSRC sequencer.
REQ-010 The block SHALL have port seq_next_ctrl, output, CTRL_WIDTH: ctrl value presented to the sequencer.
REQ-011 The block SHALL have port seq_done, input, 1: sequence-complete pulse (sequencer tx_data_start).
REQ-012 The block SHALL have port timeout_cycles, input, TIMEOUT_WIDTH: wait limit in clk cycles; 0 disables the timeout.
REQ-013 The block SHALL have port err_clear, input, 1: clears timeout_err.
REQ-014 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 The block SHALL have port grant_id, output, clog2(NUM_REQ): index of the current or last granted requester.
REQ-016 The block SHALL have port done_pulse, output, 1: single-cycle completion indication.
REQ-017 The block SHALL have port timeout_err, output, 1: sticky timeout flag.

Function
REQ-018 The state machine SHALL have states IDLE, START, WAIT and DONE.
REQ-019 In IDLE with any req_valid high, the arbiter SHALL select a winner round-robin, searching upward from last_grant+1 with wrap to 0.
REQ-020 In that same cycle, the arbiter SHALL assert req_ready[winner] combinationally and register the handshake.
REQ-021 On the handshake, seq_next_ctrl SHALL load req_ctrl[winner], grant_id SHALL load the winner index, and the state SHALL go to START.
REQ-022 req_ready SHALL be all-zero outside IDLE and when no req_valid is high; at most one bit SHALL ever be set.
REQ-023 In START, seq_start SHALL be 1 for exactly one cycle, the timeout counter SHALL load timeout_cycles, and the state SHALL go to WAIT.
REQ-024 seq_start SHALL occur exactly 2 cycles after the handshake edge.
REQ-025 In WAIT, the timeout counter SHALL decrement by 1 per cycle and saturate at 0; when timeout_cycles==0 the counter SHALL be ignored and the block SHALL wait indefinitely.
REQ-026 In WAIT with seq_done high, the state SHALL go to DONE.
REQ-027 In WAIT with the counter at 1, timeout enabled and seq_done low, timeout_err SHALL set and the state SHALL go to DONE.
REQ-028 When seq_done and timeout expiry coincide, seq_done SHALL win and timeout_err SHALL NOT set.
REQ-029 seq_done SHALL be ignored in IDLE, START and DONE.
REQ-030 In DONE, done_pulse SHALL be 1 for one cycle, last_grant SHALL update to grant_id, and the state SHALL return to IDLE.
REQ-031 The minimum handshake-to-handshake spacing SHALL be 4 cycles (IDLE, START, WAIT, DONE).
REQ-032 seq_next_ctrl SHALL hold its value from handshake until the next handshake, regardless of req_ctrl changes.
REQ-033 timeout_err SHALL be cleared by err_clear; if set and clear occur in the same cycle, set SHALL win.
REQ-034 A requester that deasserts req_valid before its grant SHALL lose its request, with no internal queuing.

Reset
REQ-035 On reset, the state SHALL be IDLE, and seq_start, done_pulse, timeout_err, busy, req_ready, seq_next_ctrl and grant_id SHALL all be 0.
REQ-036 On reset, last_grant SHALL be NUM_REQ-1, so requester 0 wins first.
REQ-037 Reset asserted in any state SHALL abort the sequence on the next edge without producing done_pulse or seq_start.

Verification
REQ-038 Scenario: single request, req_valid[1]=1, req_ctrl[1]=0x12_3456_789A, seq_done 5 cycles after seq_start -> req_ready=2'b10 for 1 cycle, seq_start +2 cycles, seq_next_ctrl=0x12_3456_789A, done_pulse 1 cycle after seq_done, busy falls with it.
REQ-039 Scenario: both requesters held high continuously after reset -> grants alternate 0,1,0,1; grant_id matches; no request is starved.
REQ-040 Scenario: timeout_cycles=10, no seq_done -> timeout_err set 10 cycles after seq_start, then done_pulse and return to IDLE; err_clear pulse -> timeout_err=0.
REQ-041 Scenario: timeout_cycles=10 with seq_done on the expiry cycle -> done_pulse and timeout_err stays 0; same case with timeout_cycles=0 and seq_done delayed 1000 cycles -> no error.
REQ-042 Scenario: reset asserted during WAIT -> all outputs 0 next cycle, and a subsequent request from requester 1 with requester 0 idle is granted normally.
REQ-043 Scenario: seq_done pulsed while in IDLE, and req_ctrl changed during WAIT -> no state change, and seq_next_ctrl is unchanged.
